lfsr_coin_stream: RTL
=====================

Name: lfsr_coin_stream

Overview:
- Parametrised Fibonacci LFSR coin generator for the NTRU-HRSS sampling path.
- Generates BITS_PER_CYC pseudo-random bits per clock and packs them into OUT_W-bit words.
- Delivers each word to the sampler over a valid/ready handshake.
- Supports run-time reseeding, a programmable tap mask, and backpressure (the LFSR freezes while a word is pending).

Parameters:
- WIDTH, 256, LFSR state width in bits.
- TAPS, (1<<255)|(1<<31)|(1<<21)|(1<<1), feedback tap mask, 0-based bit indices; bit WIDTH-1 must be set.
- DEFAULT_SEED, 65536, state loaded at reset; must be nonzero.
- OUT_W, 32, output word width.
- BITS_PER_CYC, 8, LFSR steps per clock; must divide OUT_W and satisfy 1 <= BITS_PER_CYC <= OUT_W.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- seed_valid  in  1  one-cycle request to load seed_data into the LFSR
- seed_data  in  WIDTH  new seed
- seed_err  out  1  one-cycle pulse: zero seed rejected
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  consumer accepts the word
- out_data  out  OUT_W  packed coin word
- busy  out  1  FSM in FILL

Behaviour:
- LFSR step: fb = XOR of state[i] over all i where TAPS[i] = 1. Then state <= {state[WIDTH-2:0], fb}.
- Each step also shifts fb into the LSB of the collect register: col <= {col[OUT_W-2:0], fb}.
- The first generated bit of a word ends at out_data[OUT_W-1].
- Steps within one cycle are applied sequentially, unrolled combinationally.
- K = OUT_W/BITS_PER_CYC fill cycles per word. A step counter cnt runs 0..K-1.
- FSM states:
  - FILL: each cycle perform BITS_PER_CYC steps and increment cnt. When cnt = K-1, load out_data from col (including this cycle's bits), set out_valid, clear cnt, and go to HOLD.
  - HOLD: LFSR and col frozen; out_data stable. On out_valid & out_ready, clear out_valid and go to FILL.
- Latency: first out_valid rises on the K-th rising edge after the cycle in which rst is sampled low. After each handshake, the next word is valid K cycles later; there is no prefetch.
- Throughput is one word per K+1 cycles with out_ready held high.
- Seed load (seed_valid = 1, seed_data != 0):
  - state <= seed_data; col and cnt cleared.
  - out_valid <= 0; FSM -> FILL.
  - This applies in any state and aborts any fill in progress.
- Seed vs handshake in the same cycle: seed_valid and (out_valid & out_ready) together means the word counts as delivered and the seed load also occurs.
- Zero seed (seed_valid = 1, seed_data = 0): ignored, with no state change. seed_err pulses high for exactly the next cycle.
- Reset values:
  - state = DEFAULT_SEED; col = 0; cnt = 0; FSM = FILL.
  - out_valid = 0, out_data = 0, seed_err = 0, busy = 1.
  - Reset has priority over seed_valid and the handshake. Reset mid-fill or in HOLD discards the pending word.
- out_data changes only on the FILL->HOLD transition or reset; it is never modified while out_valid = 1.
- Nonzero state is invariant: TAPS[WIDTH-1] = 1 makes the map invertible, so the lock-up state is unreachable.

Optional Feature:
- Macro: LFSR_COIN_STREAM_WORD_CNT_EN.
- When defined:
  - Extra output port word_cnt [31:0]: number of completed handshakes.
  - Resets to 0 and wraps 0xFFFFFFFF -> 0.
  - Also cleared on an accepted (nonzero) seed load, unless a handshake completes in that same cycle, in which case it is set to 1.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- OUT_W=8, BITS_PER_CYC=1, default seed/taps, out_ready=1 -> out_valid rises 8 cycles after reset release, out_data = 0x05 (bits 0,0,0,0,0,1,0,1).
- Same, with BITS_PER_CYC=8 -> out_valid after 1 cycle, out_data = 0x05. Concatenated words over 64 handshakes match the BITS_PER_CYC=1 run bit-for-bit.
- Default params, out_ready=0 for 20 cycles after out_valid -> out_data and internal state unchanged. Then raise out_ready -> one transfer, out_valid low next cycle, next word valid 4 cycles later.
- Seed load of 256'h1 mid-fill (cnt=2) -> out_valid stays 0; the next word equals a fresh-run golden model seeded with 1. Seed 0 -> seed_err pulses once, and the output stream is identical to a run without the seed pulse.
- seed_valid coincident with an accepted handshake -> the word counts as delivered (word_cnt=1 with LFSR_COIN_STREAM_WORD_CNT_EN) and the next word comes from the new seed. rst asserted while in HOLD -> out_valid=0 next cycle, stream restarts from DEFAULT_SEED.
- Random out_ready/seed_valid for 10k cycles against a bit-serial reference model -> no mismatch, out_data never changes while out_valid=1.

Source files
------------

// File: rtl/lfsr_coin_stream.sv
// rtl/lfsr_coin_stream.sv - Fibonacci LFSR coin generator packing bits into handshaked words
//
// Purpose:
//   Steps a WIDTH-bit Fibonacci LFSR BITS_PER_CYC times per clock, collects
//   the feedback bits into OUT_W-bit words (first bit lands in the MSB) and
//   offers each word on a valid/ready handshake. The LFSR is frozen while a
//   word waits for the consumer. The seed and run state can be reloaded at
//   any time; a zero seed is rejected.
//
// Optional build macro:
//   LFSR_COIN_STREAM_WORD_CNT_EN - adds the word_cnt output (handshake counter).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   seed_valid in   1      one-cycle request to load seed_data
//   seed_data  in   WIDTH  new LFSR state
//   seed_err   out  1      one-cycle pulse after a zero seed was rejected
//   out_valid  out  1      out_data holds a complete word
//   out_ready  in   1      consumer accepts the word
//   out_data   out  OUT_W  packed coin word
//   busy       out  1      generator is filling a word
//   word_cnt   out  32     completed handshakes (only with the macro)

module lfsr_coin_stream #(
   parameter int                 WIDTH        = 256,
   parameter logic [WIDTH-1:0]   TAPS         = (256'b1 << 255) | (256'b1 << 31) |
                                                (256'b1 << 21)  | (256'b1 << 1),
   parameter logic [WIDTH-1:0]   DEFAULT_SEED = WIDTH'(65536),
   parameter int                 OUT_W        = 32,
   parameter int                 BITS_PER_CYC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_valid,
   input  logic [WIDTH-1:0] seed_data,
   output logic             seed_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
`ifdef LFSR_COIN_STREAM_WORD_CNT_EN
   output logic [31:0]      word_cnt,
`endif
   output logic             busy
);

   localparam int K     = OUT_W / BITS_PER_CYC;
   localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t           fsm;
   logic [WIDTH-1:0] lfsr;
   logic [OUT_W-1:0] col;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] lfsr_next;
   logic [OUT_W-1:0] col_next;
   logic             handshake;
   logic             seed_ok;

   assign handshake = out_valid & out_ready;
   assign seed_ok   = seed_valid & (seed_data != '0);

   // BITS_PER_CYC sequential LFSR steps unrolled into one combinational cone.
   always_comb begin
      logic fb;
      lfsr_next = lfsr;
      col_next  = col;
      fb        = 1'b0;
      for (int i = 0; i < BITS_PER_CYC; i++) begin
         fb        = ^(lfsr_next & TAPS);
         lfsr_next = {lfsr_next[WIDTH-2:0], fb};
         col_next  = {col_next[OUT_W-2:0], fb};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= FILL;
         lfsr      <= DEFAULT_SEED;
         col       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         seed_err  <= 1'b0;
         busy      <= 1'b1;
`ifdef LFSR_COIN_STREAM_WORD_CNT_EN
         word_cnt  <= '0;
`endif
      end else begin
         // A zero seed would lock the LFSR up, so it is dropped and flagged.
         seed_err <= seed_valid & (seed_data == '0);

`ifdef LFSR_COIN_STREAM_WORD_CNT_EN
         if (seed_ok)
            word_cnt <= handshake ? 32'd1 : 32'd0;
         else if (handshake)
            word_cnt <= word_cnt + 32'd1;
`endif

         if (seed_ok) begin
            // Reseed overrides everything; a word handed over this same
            // cycle still counts as delivered via the handshake above.
            lfsr      <= seed_data;
            col       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            fsm       <= FILL;
         end else begin
            case (fsm)
               FILL: begin
                  lfsr <= lfsr_next;
                  col  <= col_next;
                  if (cnt == CNT_W'(K - 1)) begin
                     out_data  <= col_next;
                     out_valid <= 1'b1;
                     cnt       <= '0;
                     busy      <= 1'b0;
                     fsm       <= HOLD;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               HOLD: begin
                  if (handshake) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b1;
                     fsm       <= FILL;
                  end
               end
               default: fsm <= FILL;
            endcase
         end
      end
   end

endmodule
